rr_grant_sequencer: RTL and testbench



---
 rtl/arb_pkg.sv | 42 ++++
 rtl/arb_id_decode.sv | 21 ++
 rtl/rr_grant_sequencer.sv | 132 +++++++++++++
 tb/tb_rr_grant_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant sequencer.
package arb_pkg;

    // Default requester count.
    localparam int unsigned ARB_N_DEFAULT = 8;

    // Widest supported requester vector (N <= 64).
    localparam int unsigned ARB_N_MAX = 64;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic       found;
        logic [5:0] idx;
    } rr_pick_t;

    // Round-robin scan: first set bit of req at ptr, ptr+1, ..., n-1, 0, ..., ptr-1.
    function automatic rr_pick_t next_rr(
        input logic [ARB_N_MAX-1:0] req,
        input logic [5:0]           ptr,
        input int unsigned          n
    );
        rr_pick_t    pick;
        int unsigned j;
        pick = '0;
        j    = 0;
        for (int unsigned k = 0; k < ARB_N_MAX; k++) begin
            if (k < n && !pick.found) begin
                j = (32'(ptr) + k) % n;
                if (req[j]) begin
                    pick.found = 1'b1;
                    pick.idx   = j[5:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arb_id_decode.sv
// Binary-to-one-hot decoder with enable; all zeros when disabled.
module arb_id_decode
    import arb_pkg::*;
#(
    parameter int unsigned N   = ARB_N_DEFAULT,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [IDW-1:0] i_id,
    input  logic           i_en,
    output logic [N-1:0]   o_onehot
);

    // Single bit at i_id when enabled, never multi-hot.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_id] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer: one owner at a time, held until done or req drop,
// one idle cycle between grants. Optional hold watchdog under ARB_TIMEOUT_EN.
module rr_grant_sequencer
    import arb_pkg::*;
#(
    parameter int unsigned N        = ARB_N_DEFAULT,
    parameter int unsigned IDW      = $clog2(N),
    parameter int unsigned MAX_HOLD = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic           gnt_valid,
    output logic [IDW-1:0] grant_id,
    output logic [N-1:0]   grant,
    output logic           timeout
);

    if (N < 2 || N > ARB_N_MAX || (N & (N - 1)) != 0 || IDW != $clog2(N) || MAX_HOLD < 1) begin : g_bad_cfg
        $error("rr_grant_sequencer: unsupported N/IDW/MAX_HOLD combination");
    end

    arb_state_t     r_state;
    arb_state_t     w_state_next;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_ptr;
    rr_pick_t       w_pick;
    logic           w_start;
    logic           w_release_norm;
    logic           w_force;
    logic           w_release;

    // Round-robin candidate from the current pointer.
    always_comb begin
        w_pick = next_rr(64'(req), 6'(r_ptr), N);
    end

    // Grant start in IDLE; release by owner done or owner withdrawal, or watchdog.
    always_comb begin
        w_start        = (r_state == IDLE) && w_pick.found;
        w_release_norm = (r_state == BUSY) && (done[r_grant_id] || !req[r_grant_id]);
        w_release      = w_release_norm || w_force;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start)   w_state_next = BUSY;
            BUSY:    if (w_release) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Owner ID capture and pointer advance past the releasing owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_id <= '0;
            r_ptr      <= '0;
        end else begin
            if (w_start) begin
                r_grant_id <= w_pick.idx[IDW-1:0];
            end
            if (w_release) begin
                r_ptr <= r_grant_id + IDW'(1);
            end
        end
    end

    // Outputs derived from registered state only.
    always_comb begin
        gnt_valid = (r_state == BUSY);
        grant_id  = r_grant_id;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] r_hold;
    logic [HW-1:0] w_hold_inc;
    logic          r_timeout;

    // The compare uses the incremented count so the forced release lands on
    // the edge closing the MAX_HOLD-th BUSY cycle.
    always_comb begin
        w_hold_inc = r_hold + HW'(1);
        w_force    = (r_state == BUSY) && (w_hold_inc == HW'(MAX_HOLD));
        timeout    = r_timeout;
    end

    // Hold counter and timeout pulse; a normal release on the same edge wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force && !w_release_norm;
            if (w_start) begin
                r_hold <= '0;
            end else if (r_state == BUSY) begin
                r_hold <= w_hold_inc;
            end
        end
    end
`else
    // No watchdog: grants are held until the owner releases.
    always_comb begin
        w_force = 1'b0;
        timeout = 1'b0;
    end
`endif

    arb_id_decode #(
        .N   (N),
        .IDW (IDW)
    ) u_dec (
        .i_id     (r_grant_id),
        .i_en     (gnt_valid),
        .o_onehot (grant)
    );

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed bench for rr_grant_sequencer (N=8). Define ARB_TIMEOUT_EN to
// exercise the watchdog with MAX_HOLD=4.
module tb_rr_grant_sequencer;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] done;
    logic       gnt_valid;
    logic [2:0] grant_id;
    logic [7:0] grant;
    logic       timeout;

    int unsigned checks = 0;
    int unsigned errors = 0;

`ifdef ARB_TIMEOUT_EN
    rr_grant_sequencer #(.N(8), .MAX_HOLD(4)) dut (
`else
    rr_grant_sequencer #(.N(8)) dut (
`endif
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .grant_id  (grant_id),
        .grant     (grant),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic v, input logic [2:0] id, input logic [7:0] g);
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(v));
        if (v) chk({tag, ".id"}, 32'(grant_id), 32'(id));
        chk({tag, ".grant"}, 32'(grant), 32'(g));
    endtask

    initial begin
        logic saw_timeout;
        rst  = 1'b1;
        req  = '0;
        done = '0;
        tick();
        tick();
        chk_grant("reset", 1'b0, 3'd0, 8'h00);
        chk("reset.id", 32'(grant_id), 32'd0);
        chk("reset.timeout", 32'(timeout), 32'd0);
        rst = 1'b0;

        // Grant req[2], then async reset mid-BUSY.
        req = 8'b0000_0100;
        #2;
        chk("latency.pre", 32'(gnt_valid), 32'd0);
        tick();
        chk_grant("g2", 1'b1, 3'd2, 8'h04);
        #2;
        rst = 1'b1;
        #1;
        chk_grant("async_rst", 1'b0, 3'd0, 8'h00);
        #1;
        rst = 1'b0;
        req = 8'b0000_0101;
        tick();
        chk_grant("post_rst", 1'b1, 3'd0, 8'h01);
        req = '0;
        tick();
        chk_grant("post_rst.rel", 1'b0, 3'd0, 8'h00);

        // Pointer back to 0, then full rotation with done one cycle after grant.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            tick();
            chk_grant($sformatf("rot%0d", k), 1'b1, 3'(k % 8), 8'(1 << (k % 8)));
            done = 8'(1 << (k % 8));
            tick();
            chk("rot.gap", 32'(gnt_valid), 32'd0);
            done = '0;
        end

        // ptr=1: id 6 then wrap 7 -> 0.
        req = 8'b0100_0000;
        tick();
        chk_grant("g6", 1'b1, 3'd6, 8'h40);
        req = '0;
        tick();
        chk_grant("g6.rel", 1'b0, 3'd0, 8'h00);
        req = 8'b1000_0001;
        tick();
        chk_grant("wrap7", 1'b1, 3'd7, 8'h80);
        done = 8'h80;
        tick();
        done = '0;
        chk("wrap.gap", 32'(gnt_valid), 32'd0);
        tick();
        chk_grant("wrap0", 1'b1, 3'd0, 8'h01);
        // Owner drops req and pulses done together: single release.
        req  = '0;
        done = 8'h01;
        tick();
        done = '0;
        chk("dual.rel", 32'(gnt_valid), 32'd0);
        tick();
        chk("dual.idle", 32'(gnt_valid), 32'd0);

        // ptr=1: owner 3, non-owner done ignored, req drop releases.
        req = 8'b0000_1000;
        tick();
        chk_grant("g3", 1'b1, 3'd3, 8'h08);
        done = 8'b0010_0000;
        tick();
        done = '0;
        chk_grant("g3.hold", 1'b1, 3'd3, 8'h08);
        req = '0;
        tick();
        chk_grant("g3.rel", 1'b0, 3'd0, 8'h00);

        // ptr=4: req and done together in IDLE -> granted, done not applied.
        req  = 8'h10;
        done = 8'h10;
        tick();
        done = '0;
        chk_grant("g4", 1'b1, 3'd4, 8'h10);
        tick();
        chk_grant("g4.hold", 1'b1, 3'd4, 8'h10);
        // Waiting requester 2 queued while 4 holds.
        req = 8'h14;
        tick();
        chk_grant("g4.queue", 1'b1, 3'd4, 8'h10);
        req = 8'h04;
        tick();
        chk("g4.rel", 32'(gnt_valid), 32'd0);
        tick();
        chk_grant("g2q", 1'b1, 3'd2, 8'h04);
        req = '0;
        tick();
        chk("g2q.rel", 32'(gnt_valid), 32'd0);

        // ptr=3: requesters 1 and 3 -> 3 first; release, then ptr=4 -> id 1.
        req = 8'h08;
        tick();
        chk_grant("g3b", 1'b1, 3'd3, 8'h08);
        req = 8'h02;
        tick();
        chk("g3b.rel", 32'(gnt_valid), 32'd0);
        req = 8'h0A;
        tick();
        chk_grant("g1", 1'b1, 3'd1, 8'h02);
`ifdef ARB_TIMEOUT_EN
        // Entry edge done; BUSY cycles 1..4, forced release at end of cycle 4.
        tick();
        tick();
        tick();
        chk_grant("to.c4", 1'b1, 3'd1, 8'h02);
        chk("to.pre", 32'(timeout), 32'd0);
        tick();
        chk("to.pulse", 32'(timeout), 32'd1);
        chk("to.rel", 32'(gnt_valid), 32'd0);
        tick();
        chk("to.clear", 32'(timeout), 32'd0);
        chk_grant("to.next", 1'b1, 3'd3, 8'h08);
`else
        // No watchdog: grant held well past 255 cycles, timeout never set.
        saw_timeout = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (timeout !== 1'b0) saw_timeout = 1'b1;
        end
        chk_grant("hold300", 1'b1, 3'd1, 8'h02);
        chk("hold.timeout", 32'(saw_timeout), 32'd0);
        req = 8'h08;
        tick();
        chk("hold.rel", 32'(gnt_valid), 32'd0);
        tick();
        chk_grant("hold.next", 1'b1, 3'd3, 8'h08);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global bound in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=stalled expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
